line_rasterizer: RTL and testbench
==================================

Name: line_rasterizer

Overview:
- Write-side producer for the double-buffered vector framebuffer.
- Pops line requests (endpoints + colour) from the line request queue and rasterizes each with integer Bresenham, one pixel per clock.
- Drives framebuffer write address/colour/enable and pulses line_done after each line.
- Its lrq_empty/line_done outputs feed the framebuffer buffer-swap handshake.

Parameters:
- H_RES, 640, visible columns; x >= H_RES is clipped.
- V_RES, 480, visible rows; y >= V_RES is clipped.
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.
- AW, 19, framebuffer address width.
- EW, 13, signed Bresenham error width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- lrq_empty  in  1  request queue empty
- lrq_x0  in  XW  start x, first-word-fall-through, valid while !lrq_empty
- lrq_y0  in  YW  start y
- lrq_x1  in  XW  end x
- lrq_y1  in  YW  end y
- lrq_color  in  4  line colour
- lrq_rd  out  1  queue pop strobe, one cycle per request
- hold  in  1  stall: freeze rasterization, suppress writes and pops
- w_addr  out  AW  framebuffer write address = y*H_RES + x
- color_w  out  4  write colour
- en_w  out  1  write enable, one pixel per asserted cycle
- line_done  out  1  one-cycle pulse after last pixel of a line
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst==0 at clock edge):
  - state=IDLE.
  - lrq_rd, en_w, line_done and busy all 0; w_addr and color_w both 0.
  - A partially drawn line is abandoned; no pop occurs in the reset cycle.
- All outputs are registered.
- IDLE:
  - If !lrq_empty && !hold: assert lrq_rd this cycle, latch x0/y0/x1/y1/colour, go to SETUP.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - err=dx+dy; cur=(x0,y0). Go to DRAW.
- DRAW, each cycle with hold==0:
  - Emit cur: en_w=1 next cycle if cur.x<H_RES && cur.y<V_RES, else en_w=0 (clipped, still stepped).
  - w_addr=cur.y*H_RES+cur.x via shift-add (y<<9)+(y<<7)+x, zero-extended to AW. color_w=latched colour.
  - If cur==(x1,y1): go to DONE.
  - Else, with e2=2*err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates use the pre-update err.
- DRAW with hold==1: cur/err frozen, en_w=0; resume identically when hold falls.
- DONE (1 cycle): line_done=1, go to IDLE.
- Pixel count per line = max(dx,|dy|)+1. A zero-length line (x0==x1, y0==y1) yields exactly one pixel.
- Latency:
  - Pop cycle T; SETUP T+1; first pixel latched T+2, visible on en_w/w_addr at T+3.
  - line_done is visible the cycle after the last en_w.
  - Minimum gap between lines is 3 cycles.
- Arithmetic:
  - err/e2 are EW-bit signed; max |e2| = 2*1023 fits.
  - dx/dy are computed from zero-extended unsigned endpoints; no wrap allowed on x/y stepping.
- Simultaneous events:
  - hold high in IDLE with !lrq_empty: no pop.
  - hold high in DONE: line_done still pulses, no stall.
  - lrq_empty rising during DRAW has no effect.
- lrq fields are sampled only in the pop cycle; later queue changes are ignored.

Test Plan:
- Horizontal line: (0,0)->(3,0) colour 5 -> en_w high for 4 consecutive cycles, w_addr 0,1,2,3, color_w=5; single line_done the next cycle; lrq_rd pulsed once.
- Steep reverse line: (2,2)->(0,5) -> w_addr 1282, 1921, 2561, 3200, then line_done; busy low afterward.
- Single point: (639,479)->(639,479) -> exactly one write at w_addr 307199, then line_done.
- Clipping: (638,10)->(641,10) -> 4 DRAW cycles; en_w only for w_addr 7038 and 7039; line_done still pulses.
- Hold and reset:
  - hold=1 for 5 cycles during the 2nd pixel of (0,0)->(3,0) -> en_w stays 0 during hold; the remaining sequence 1,2,3 is unchanged after release.
  - rst=0 mid-line -> all outputs 0 next cycle; next queued line drawn from its start.
- Back-to-back: queue holds 2 lines, then empty -> exactly 2 lrq_rd pulses; 3-cycle gap between last en_w of line 1 and first en_w of line 2; 2 line_done pulses; then idle with busy=0.

Source files
------------

// File: rtl/line_rasterizer.sv
// line_rasterizer: write-side producer for the vector framebuffer.
// Pops one line request at a time, rasterizes it with integer Bresenham at
// one pixel per clock, and drives registered framebuffer write signals.
module line_rasterizer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int AW    = 19,
  parameter int EW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lrq_empty,
  input  logic [XW-1:0] lrq_x0,
  input  logic [YW-1:0] lrq_y0,
  input  logic [XW-1:0] lrq_x1,
  input  logic [YW-1:0] lrq_y1,
  input  logic [3:0]    lrq_color,
  output logic          lrq_rd,
  input  logic          hold,
  output logic [AW-1:0] w_addr,
  output logic [3:0]    color_w,
  output logic          en_w,
  output logic          line_done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [XW-1:0] H_LIM = XW'(H_RES);
  localparam logic [YW-1:0] V_LIM = YW'(V_RES);

  state_t               state_q, state_d;
  logic [XW-1:0]        cur_x_q, cur_x_d;
  logic [YW-1:0]        cur_y_q, cur_y_d;
  logic [XW-1:0]        x1_q, x1_d;
  logic [YW-1:0]        y1_q, y1_d;
  logic [3:0]           color_q, color_d;
  logic signed [EW-1:0] dx_q, dx_d;
  logic signed [EW-1:0] dy_q, dy_d;
  logic signed [EW-1:0] err_q, err_d;
  logic                 sx_neg_q, sx_neg_d;
  logic                 sy_neg_q, sy_neg_d;

  logic                 lrq_rd_q, lrq_rd_d;
  logic [AW-1:0]        w_addr_q, w_addr_d;
  logic [3:0]           color_w_q, color_w_d;
  logic                 en_w_q, en_w_d;
  logic                 line_done_q, line_done_d;
  logic                 busy_q, busy_d;

  logic [XW-1:0]        dx_abs_s;
  logic [YW-1:0]        dy_abs_s;
  logic signed [EW-1:0] e2_s;
  logic signed [EW-1:0] err_n_s;
  logic [AW-1:0]        addr_s;
  logic                 visible_s;
  logic                 at_end_s;

  // Datapath helpers: endpoint deltas, pixel address, clip test, end test.
  always_comb begin
    dx_abs_s  = (x1_q >= cur_x_q) ? (x1_q - cur_x_q) : (cur_x_q - x1_q);
    dy_abs_s  = (y1_q >= cur_y_q) ? (y1_q - cur_y_q) : (cur_y_q - y1_q);
    e2_s      = $signed({err_q[EW-2:0], 1'b0});
    // y*640 + x as (y<<9) + (y<<7) + x
    addr_s    = AW'({cur_y_q, 9'd0}) + AW'({cur_y_q, 7'd0}) + AW'(cur_x_q);
    visible_s = (cur_x_q < H_LIM) && (cur_y_q < V_LIM);
    at_end_s  = (cur_x_q == x1_q) && (cur_y_q == y1_q);
  end

  // Next-state and registered-output logic for the rasterizer FSM.
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    lrq_rd_d    = 1'b0;
    w_addr_d    = w_addr_q;
    color_w_d   = color_w_q;
    en_w_d      = 1'b0;
    line_done_d = 1'b0;
    err_n_s     = err_q;

    case (state_q)
      IDLE: begin
        if (!lrq_empty && !hold) begin
          // Start point is held directly in the cursor registers.
          lrq_rd_d = 1'b1;
          cur_x_d  = lrq_x0;
          cur_y_d  = lrq_y0;
          x1_d     = lrq_x1;
          y1_d     = lrq_y1;
          color_d  = lrq_color;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        dx_d     = $signed({{(EW-XW){1'b0}}, dx_abs_s});
        dy_d     = -$signed({{(EW-YW){1'b0}}, dy_abs_s});
        err_d    = $signed({{(EW-XW){1'b0}}, dx_abs_s})
                 - $signed({{(EW-YW){1'b0}}, dy_abs_s});
        sx_neg_d = !(cur_x_q < x1_q);
        sy_neg_d = !(cur_y_q < y1_q);
        state_d  = DRAW;
      end
      DRAW: begin
        if (!hold) begin
          en_w_d    = visible_s;
          w_addr_d  = addr_s;
          color_w_d = color_q;
          if (at_end_s) begin
            state_d = DONE;
          end else begin
            // Both tests use e2 from the pre-update error.
            if (e2_s >= dy_q) begin
              err_n_s = err_n_s + dy_q;
              cur_x_d = sx_neg_q ? (cur_x_q - XW'(1)) : (cur_x_q + XW'(1));
            end else begin
              cur_x_d = cur_x_q;
            end
            if (e2_s <= dx_q) begin
              err_n_s = err_n_s + dx_q;
              cur_y_d = sy_neg_q ? (cur_y_q - YW'(1)) : (cur_y_q + YW'(1));
            end else begin
              cur_y_d = cur_y_q;
            end
            err_d = err_n_s;
          end
        end else begin
          en_w_d = 1'b0;
        end
      end
      DONE: begin
        line_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      lrq_rd_q    <= 1'b0;
      w_addr_q    <= '0;
      color_w_q   <= '0;
      en_w_q      <= 1'b0;
      line_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      lrq_rd_q    <= lrq_rd_d;
      w_addr_q    <= w_addr_d;
      color_w_q   <= color_w_d;
      en_w_q      <= en_w_d;
      line_done_q <= line_done_d;
      busy_q      <= busy_d;
    end
  end

  assign lrq_rd    = lrq_rd_q;
  assign w_addr    = w_addr_q;
  assign color_w   = color_w_q;
  assign en_w      = en_w_q;
  assign line_done = line_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: directed and randomized checks of line_rasterizer
// against a pixel-list model of Bresenham rasterization.
module tb_line_rasterizer;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrq_empty;
  logic [9:0]  lrq_x0, lrq_x1;
  logic [8:0]  lrq_y0, lrq_y1;
  logic [3:0]  lrq_color;
  logic        lrq_rd;
  logic        hold;
  logic [18:0] w_addr;
  logic [3:0]  color_w;
  logic        en_w, line_done, busy;

  always #5 clk = ~clk;

  line_rasterizer dut (
    .clk(clk), .rst(rst), .lrq_empty(lrq_empty),
    .lrq_x0(lrq_x0), .lrq_y0(lrq_y0), .lrq_x1(lrq_x1), .lrq_y1(lrq_y1),
    .lrq_color(lrq_color), .lrq_rd(lrq_rd), .hold(hold),
    .w_addr(w_addr), .color_w(color_w), .en_w(en_w),
    .line_done(line_done), .busy(busy)
  );

  typedef struct {int x0; int y0; int x1; int y1; int c;} req_t;
  typedef struct {int addr; bit vis; bit last; int c;} px_t;
  typedef struct {int cyc; int addr; int c;} wr_t;

  req_t reqs[$];
  px_t  exp_q[$];
  wr_t  wlog[$];
  int   dlog[$];
  int   rlog[$];
  int   head = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   last_seen = 1'b0;
  int   expect_done_cyc = -1;
  int   expect_first_cyc = -1;

  function automatic void chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Pixel list of one line by plain integer Bresenham, appended to exp_q.
  function automatic void gen_pixels(input req_t r);
    int dx, dy, sx, sy, err, e2, x, y, n, want;
    px_t p;
    dx = iabs(r.x1 - r.x0);
    dy = -iabs(r.y1 - r.y0);
    sx = (r.x0 < r.x1) ? 1 : -1;
    sy = (r.y0 < r.y1) ? 1 : -1;
    err = dx + dy;
    x = r.x0; y = r.y0; n = 0;
    for (int k = 0; k < 4096; k++) begin
      p.addr = y * H_RES + x;
      p.vis  = (x < H_RES) && (y < V_RES);
      p.last = (x == r.x1) && (y == r.y1);
      p.c    = r.c;
      exp_q.push_back(p);
      n++;
      if (p.last) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    want = ((dx > -dy) ? dx : -dy) + 1;
    chk(n == want, "model_pixel_count", n, want);
  endfunction

  function automatic void update_q();
    if (head < reqs.size()) begin
      lrq_empty = 1'b0;
      lrq_x0    = 10'(reqs[head].x0);
      lrq_y0    = 9'(reqs[head].y0);
      lrq_x1    = 10'(reqs[head].x1);
      lrq_y1    = 9'(reqs[head].y1);
      lrq_color = 4'(reqs[head].c);
    end else begin
      lrq_empty = 1'b1;
    end
  endfunction

  task automatic load(input int x0, input int y0, input int x1, input int y1, input int c);
    req_t r;
    r.x0 = x0; r.y0 = y0; r.x1 = x1; r.y1 = y1; r.c = c;
    reqs.push_back(r);
    update_q();
  endtask

  task automatic clear_logs();
    wlog.delete(); dlog.delete(); rlog.delete();
  endtask

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk); #1;
      if (head >= reqs.size() && !busy && !lrq_rd) break;
    end
    chk(k < limit, "idle_timeout", k, limit);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Monitor and compare process: logs activity and checks every output cycle.
  bit ok, found, bad;
  int idx;
  wr_t w;
  always @(negedge clk) begin
    cyc++;
    if (en_w) begin
      w.cyc = cyc; w.addr = int'(w_addr); w.c = int'(color_w);
      wlog.push_back(w);
    end
    if (line_done) dlog.push_back(cyc);
    if (lrq_rd) begin
      rlog.push_back(cyc);
      if (head < reqs.size()) begin
        idx = exp_q.size();
        gen_pixels(reqs[head]);
        expect_first_cyc = exp_q[idx].vis ? cyc + 2 : -1;
        head++;
        update_q();
      end
    end
    if (cyc == expect_first_cyc) chk(en_w, "first_pixel_latency", int'(en_w), 1);
    if (en_w) begin
      while (exp_q.size() > 0 && !exp_q[0].vis && !exp_q[0].last) exp_q.delete(0);
      ok = (exp_q.size() > 0) && exp_q[0].vis;
      chk(ok, "write_expected", int'(w_addr), -1);
      if (ok) begin
        chk(int'(w_addr) == exp_q[0].addr, "w_addr", int'(w_addr), exp_q[0].addr);
        chk(int'(color_w) == exp_q[0].c, "color_w", int'(color_w), exp_q[0].c);
        if (exp_q[0].last) begin
          last_seen = 1'b1;
          expect_done_cyc = cyc + 1;
        end
        exp_q.delete(0);
      end
    end
    if (cyc == expect_done_cyc) chk(line_done, "done_after_last_write", int'(line_done), 1);
    if (line_done) begin
      ok = last_seen;
      if (!last_seen) begin
        found = 1'b0; bad = 1'b0;
        while (exp_q.size() > 0 && !found) begin
          if (exp_q[0].vis) bad = 1'b1;
          found = exp_q[0].last;
          exp_q.delete(0);
        end
        ok = found && !bad;
      end
      last_seen = 1'b0;
      chk(ok, "line_done_boundary", int'(ok), 1);
    end
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int k, hw, mode, x0, y0, x1, y1;
  int t2_exp[4];
  initial begin
    rst = 1'b0; hold = 1'b0;
    lrq_x0 = '0; lrq_y0 = '0; lrq_x1 = '0; lrq_y1 = '0; lrq_color = '0;
    update_q();
    repeat (3) @(negedge clk);
    #1;
    chk(!busy && !en_w && !line_done && !lrq_rd, "reset_ctrl",
        {28'd0, busy, en_w, line_done, lrq_rd}, 0);
    chk(w_addr == 19'd0 && color_w == 4'd0, "reset_data", int'(w_addr) + int'(color_w), 0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Horizontal line
    clear_logs(); load(0, 0, 3, 0, 5); wait_idle(100);
    chk(wlog.size() == 4, "t1_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      chk(wlog[i].addr == i, "t1_addr", wlog[i].addr, i);
      chk(wlog[i].c == 5, "t1_color", wlog[i].c, 5);
      chk(wlog[i].cyc == rlog[0] + 2 + i, "t1_timing", wlog[i].cyc, rlog[0] + 2 + i);
    end
    chk(rlog.size() == 1, "t1_pops", rlog.size(), 1);
    chk(dlog.size() == 1, "t1_dones", dlog.size(), 1);
    chk(dlog[0] == rlog[0] + 6, "t1_done_cycle", dlog[0], rlog[0] + 6);

    // Steep reverse line
    clear_logs(); load(2, 2, 0, 5, 9); wait_idle(100);
    t2_exp = '{1282, 1921, 2561, 3200};
    chk(wlog.size() == 4, "t2_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++)
      chk(wlog[i].addr == t2_exp[i], "t2_addr", wlog[i].addr, t2_exp[i]);
    chk(dlog.size() == 1, "t2_dones", dlog.size(), 1);
    chk(!busy, "t2_busy_after", int'(busy), 0);

    // Single point at the far corner
    clear_logs(); load(639, 479, 639, 479, 3); wait_idle(100);
    chk(wlog.size() == 1, "t3_writes", wlog.size(), 1);
    chk(wlog[0].addr == 307199, "t3_addr", wlog[0].addr, 307199);
    chk(dlog.size() == 1, "t3_dones", dlog.size(), 1);

    // Clipping on the right edge
    clear_logs(); load(638, 10, 641, 10, 6); wait_idle(100);
    chk(wlog.size() == 2, "t4_writes", wlog.size(), 2);
    chk(wlog[0].addr == 7038, "t4_addr0", wlog[0].addr, 7038);
    chk(wlog[1].addr == 7039, "t4_addr1", wlog[1].addr, 7039);
    chk(dlog.size() == 1, "t4_dones", dlog.size(), 1);
    chk(dlog[0] - rlog[0] == 6, "t4_draw_cycles", dlog[0] - rlog[0], 6);

    // Hold for 5 cycles during the second pixel
    clear_logs(); load(0, 0, 3, 0, 5);
    for (k = 0; k < 50; k++) begin @(negedge clk); #1; if (en_w) break; end
    chk(k < 50, "t5_first_write_timeout", k, 50);
    hold = 1'b1; hw = 0;
    repeat (5) begin @(negedge clk); #1; if (en_w) hw++; end
    hold = 1'b0;
    chk(hw == 0, "t5_en_w_in_hold", hw, 0);
    wait_idle(100);
    chk(wlog.size() == 4, "t5_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++)
      chk(wlog[i].addr == i, "t5_addr", wlog[i].addr, i);
    chk(wlog[1].cyc - wlog[0].cyc == 6, "t5_gap_hold", wlog[1].cyc - wlog[0].cyc, 6);
    chk(wlog[3].cyc - wlog[1].cyc == 2, "t5_resume", wlog[3].cyc - wlog[1].cyc, 2);

    // Reset in the middle of a line, second line queued
    clear_logs(); load(0, 0, 5, 0, 3); load(0, 1, 2, 1, 7);
    for (k = 0; k < 50; k++) begin @(negedge clk); #1; if (wlog.size() >= 2) break; end
    chk(k < 50, "t6_write_timeout", k, 50);
    rst = 1'b0;
    @(negedge clk); #1;
    chk(!en_w && !line_done && !busy && !lrq_rd, "t6_reset_ctrl",
        {28'd0, busy, en_w, line_done, lrq_rd}, 0);
    chk(w_addr == 19'd0, "t6_reset_addr", int'(w_addr), 0);
    chk(color_w == 4'd0, "t6_reset_color", int'(color_w), 0);
    chk(rlog.size() == 1, "t6_no_pop_in_reset", rlog.size(), 1);
    exp_q.delete(); last_seen = 1'b0; expect_done_cyc = -1; expect_first_cyc = -1;
    rst = 1'b1;
    clear_logs(); wait_idle(100);
    chk(wlog.size() == 3, "t6_writes", wlog.size(), 3);
    for (int i = 0; i < wlog.size() && i < 3; i++) begin
      chk(wlog[i].addr == 640 + i, "t6_addr", wlog[i].addr, 640 + i);
      chk(wlog[i].c == 7, "t6_color", wlog[i].c, 7);
    end
    chk(dlog.size() == 1, "t6_dones", dlog.size(), 1);

    // Back-to-back lines
    clear_logs(); load(0, 0, 2, 0, 1); load(5, 5, 5, 7, 2); wait_idle(100);
    chk(rlog.size() == 2, "t7_pops", rlog.size(), 2);
    chk(dlog.size() == 2, "t7_dones", dlog.size(), 2);
    chk(wlog.size() == 6, "t7_writes", wlog.size(), 6);
    chk(wlog[3].cyc - wlog[2].cyc == 4, "t7_gap", wlog[3].cyc - wlog[2].cyc, 4);
    chk(wlog[5].addr == 4485, "t7_last_addr", wlog[5].addr, 4485);
    chk(!busy, "t7_busy_after", int'(busy), 0);

    // Randomized lines, including off-screen and corner regions
    clear_logs();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        mode = $urandom_range(0, 2);
        if (mode == 0) begin
          x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 511);
          x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 511);
        end else if (mode == 1) begin
          x0 = $urandom_range(620, 660); y0 = $urandom_range(460, 500);
          x1 = clampi(x0 + $urandom_range(0, 60) - 30, 0, 1023);
          y1 = clampi(y0 + $urandom_range(0, 60) - 30, 0, 511);
        end else begin
          x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 511);
          x1 = clampi(x0 + $urandom_range(0, 16) - 8, 0, 1023);
          y1 = clampi(y0 + $urandom_range(0, 16) - 8, 0, 511);
        end
        load(x0, y0, x1, y1, $urandom_range(0, 15));
      end
      wait_idle(40000);
      chk(exp_q.size() == 0, "rand_leftover_pixels", exp_q.size(), 0);
    end
    chk(rlog.size() == 40, "rand_pops", rlog.size(), 40);
    chk(dlog.size() == 40, "rand_dones", dlog.size(), 40);
    chk(!busy, "rand_busy_after", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
